c_element_sync: RTL

- Clocked, parametrised generalisation of the two-input Muller C-element for the arbiter path.
- Takes N_IN asynchronous request/acknowledge lines and synchronises each line into the clk domain.
- Applies C-element consensus with optional asymmetric (plus-only) inputs and a FILTER_CYC-cycle consensus filter.
- Drives a registered output, one-cycle edge pulses and a transition counter for downstream handshake logic.

---
 rtl/c_elem_pkg.sv | 36 +++
 rtl/sync_bit.sv | 24 ++
 rtl/c_element_sync.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/c_elem_pkg.sv
// Shared types, limits and consensus helper for c_element_sync.
package c_elem_pkg;

    localparam int unsigned N_IN_MAX   = 16;
    localparam int unsigned FILTER_MAX = 255;

    // Output-state machine: y is high in HIGH and FALL_PEND
    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_PEND = 2'd1,
        HIGH      = 2'd2,
        FALL_PEND = 2'd3
    } c_state_e;

    // Returns {rise, fall}: rise needs every input high, fall ignores plus-only inputs
    function automatic logic [1:0] consensus_masks(
        input logic [N_IN_MAX-1:0] s,
        input logic [N_IN_MAX-1:0] plus_mask,
        input int unsigned         n_in
    );
        logic rise;
        logic fall;
        rise = 1'b1;
        fall = 1'b1;
        for (int unsigned i = 0; i < N_IN_MAX; i++) begin
            if (i < n_in) begin
                rise = rise & s[i];
                if (!plus_mask[i]) begin
                    fall = fall & ~s[i];
                end
            end
        end
        return {rise, fall};
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchroniser with asynchronous active-high reset.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/c_element_sync.sv
// Clocked N-input Muller C-element with per-input synchronisers, plus-only
// inputs, a consecutive-cycle consensus filter, edge pulses and a toggle count.
// Optional mixed-input timeout flag enabled by defining C_ELEM_TIMEOUT_EN.
module c_element_sync
    import c_elem_pkg::*;
#(
    parameter int unsigned       N_IN        = 2,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter int unsigned       FILTER_CYC  = 1,
    parameter logic [N_IN-1:0]   PLUS_MASK   = {N_IN{1'b0}},
    parameter int unsigned       CNT_W       = 16,
    parameter int unsigned       TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  a_in,
    output logic             y,
    output logic             y_rise,
    output logic             y_fall,
    output logic             pend,
    output logic [CNT_W-1:0] tog_cnt,
    output logic             err,
    input  logic             err_clr
);

    // Elaboration-time parameter legality
    generate
        if (N_IN < 2 || N_IN > N_IN_MAX) begin : g_bad_n_in
            $error("c_element_sync: N_IN out of range 2..16");
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("c_element_sync: SYNC_STAGES out of range 2..4");
        end
        if (FILTER_CYC < 1 || FILTER_CYC > FILTER_MAX) begin : g_bad_filter
            $error("c_element_sync: FILTER_CYC out of range 1..255");
        end
        if (PLUS_MASK == {N_IN{1'b1}}) begin : g_bad_mask
            $error("c_element_sync: PLUS_MASK must not be all ones");
        end
        if (TIMEOUT_CYC < 1) begin : g_bad_timeout
            $error("c_element_sync: TIMEOUT_CYC must be at least 1");
        end
    endgenerate

    logic [N_IN-1:0] s;
    logic [1:0]      cons_c;
    logic            rise_c;
    logic            fall_c;

    // One synchroniser chain per input line
    for (genvar i = 0; i < N_IN; i++) begin : g_sync
        sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (a_in[i]),
            .q   (s[i])
        );
    end

    assign cons_c = consensus_masks(N_IN_MAX'(s), N_IN_MAX'(PLUS_MASK), N_IN);
    assign rise_c = cons_c[1];
    assign fall_c = cons_c[0];

    c_state_e   state_q;
    c_state_e   state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       y_d;
    logic       pend_d;
    logic       filt_done_c;

    assign filt_done_c = ((9'(cnt_q) + 9'd1) == 9'(FILTER_CYC));

    // State and filter-count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: consensus must persist FILTER_CYC cycles, anything else holds
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOW: begin
                if (rise_c) begin
                    cnt_d   = 8'd1;
                    state_d = (FILTER_CYC == 32'd1) ? HIGH : RISE_PEND;
                end
            end
            RISE_PEND: begin
                if (!rise_c) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (filt_done_c) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HIGH: begin
                if (fall_c) begin
                    cnt_d   = 8'd1;
                    state_d = (FILTER_CYC == 32'd1) ? LOW : FALL_PEND;
                end
            end
            FALL_PEND: begin
                if (!fall_c) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (filt_done_c) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
        y_d    = (state_d == HIGH) || (state_d == FALL_PEND);
        pend_d = (state_d == RISE_PEND) || (state_d == FALL_PEND);
    end

    // Registered outputs, updated on the same edge as the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y       <= 1'b0;
            pend    <= 1'b0;
            y_rise  <= 1'b0;
            y_fall  <= 1'b0;
            tog_cnt <= '0;
        end else begin
            y      <= y_d;
            pend   <= pend_d;
            y_rise <= y_d & ~y;
            y_fall <= ~y_d & y;
            if (y_d != y) begin
                tog_cnt <= tog_cnt + CNT_W'(1);
            end
        end
    end

`ifdef C_ELEM_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q;

    // Saturating mixed-input counter and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            err      <= 1'b0;
        end else begin
            if (rise_c || fall_c) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q != TO_W'(TIMEOUT_CYC)) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
            if (err_clr) begin
                err <= 1'b0;
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYC)) begin
                err <= 1'b1;
            end
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err            = 1'b0;
`endif

endmodule
